// File: rtl/adder16_seq_pkg.sv
// rtl/adder16_seq_pkg.sv - shared state encoding and default slice count for adder16_seq
package adder16_seq_pkg;

   localparam int NIBBLES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/adder4c.sv
// rtl/adder4c.sv - combinational 4-bit slice adder with carry in/out
module adder4c (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] sum5;

   assign sum5    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   assign {cout, s} = sum5;

endmodule

// File: rtl/adder16_seq.sv
// rtl/adder16_seq.sv - nibble-serial adder, one shared 4-bit slice, LSB slice first
// Define ADDER16_SEQ_SUB_EN to add the op port and subtract support.
module adder16_seq
   import adder16_seq_pkg::*;
#(
   parameter int NIBBLES = NIBBLES_DEF
) (
   input  logic                 clk,
   input  logic                 clr_n,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
`ifdef ADDER16_SEQ_SUB_EN
   input  logic                 op,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] s,
   output logic                 cf
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    s_q, s_d;
   logic            cf_q, cf_d;

   logic [W-1:0]    b_load;
   logic            c_load;
   logic [IW+1:0]   bit_lo;
   logic [3:0]      slice_s;
   logic            slice_c;

   // Subtraction is A + ~B + 1, so B is stored already inverted and no op flag is kept.
`ifdef ADDER16_SEQ_SUB_EN
   assign b_load = op ? ~b : b;
   assign c_load = op;
`else
   assign b_load = b;
   assign c_load = 1'b0;
`endif

   assign bit_lo = {idx_q, 2'b00};

   adder4c u_slice (
      .a    (a_q[bit_lo +: 4]),
      .b    (b_q[bit_lo +: 4]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_c)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (idx_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      acc_d   = acc_q;
      s_d     = s_q;
      cf_d    = cf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b_load;
               idx_d   = '0;
               carry_d = c_load;
               acc_d   = '0;
            end
         end
         RUN: begin
            acc_d[bit_lo +: 4] = slice_s;
            carry_d            = slice_c;
            // idx holds at the last slice rather than wrapping.
            if (idx_q == LAST) begin
               s_d  = acc_d;
               cf_d = slice_c;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         acc_q   <= '0;
         s_q     <= '0;
         cf_q    <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         cf_q    <= cf_d;
      end
   end

   assign s  = s_q;
   assign cf = cf_q;

endmodule
